// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner_if
// Description : Keypad matrix and key-event bundle. The master side drives
//               the row lines and delivers key events. The slave side is
//               the keypad matrix plus the data-input port that latches them.
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_scanner_if;
  logic [3:0] rows;          // row drive, active-low, exactly one bit low
  logic [3:0] cols;          // column sense, active-low, asynchronous
  logic [3:0] keyboard_bus;  // code of the last accepted key
  logic       key_pressed;   // one-cycle strobe for a new code

  modport master (
    output rows,
    output keyboard_bus,
    output key_pressed,
    input  cols
  );

  modport slave (
    input  rows,
    input  keyboard_bus,
    input  key_pressed,
    output cols
  );
endinterface
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : Scans a 4x4 active-low keypad matrix one row at a time and
//               reduces each full scan to one (valid, code) result. Scan
//               results are debounced, and each physical press produces a
//               single key_pressed strobe with the key code on keyboard_bus.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_DIV       = 8,  // cycles each row is driven, 3..255
  parameter int DEBOUNCE_SCANS = 3   // matching scans to accept/release, 1..15
) (
  input  wire logic          clock,
  input  wire logic          reset,
  keypad_scanner_if.master   kbd
);

  localparam logic [7:0] C_DIV_LAST = 8'(SCAN_DIV - 1);
  localparam logic [3:0] C_DEB      = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CAND   = 2'd1,
    ST_ACCEPT = 2'd2,
    ST_HELD   = 2'd3
  } state_t;

  // Scan timing
  logic [7:0] div_q,   div_d;
  logic [1:0] row_q,   row_d;
  logic [3:0] rows_q,  rows_d;

  // Column synchronizer
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;

  // Per-scan result accumulator
  logic       acc_valid_q, acc_valid_d;
  logic [3:0] acc_code_q,  acc_code_d;

  // Debounce state
  state_t     state_q, state_d;
  logic [3:0] cand_q,  cand_d;
  logic [3:0] cnt_q,   cnt_d;
  logic [3:0] rel_q,   rel_d;

  // Output registers
  logic [3:0] bus_q,    bus_d;
  logic       strobe_q, strobe_d;

  // Combinational scan decode
  logic       w_sample;
  logic       w_scan_end;
  logic [3:0] w_hit_cols;
  logic       w_hit;
  logic [1:0] w_col;
  logic [3:0] w_row_code;
  logic       w_scan_valid;
  logic [3:0] w_scan_code;

  // Decode the sample point and the lowest-numbered hit column in this row
  always_comb begin
    w_sample   = (div_q == C_DIV_LAST);
    w_scan_end = w_sample && (row_q == 2'd3);
    w_hit_cols = ~sync2_q;
    w_hit      = |w_hit_cols;
    w_col      = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_hit_cols[i]) begin
        w_col = 2'(i);
      end
    end
    w_row_code = {row_q, w_col};
    // At scan end the accumulator holds rows 0..2; row 3 is folded in here
    // so the debouncer sees the complete scan in the same cycle.
    w_scan_valid = acc_valid_q || w_hit;
    w_scan_code  = acc_valid_q ? acc_code_q : w_row_code;
  end

  // Row divider, row walk, synchronizer and result accumulation
  always_comb begin
    div_d       = div_q;
    row_d       = row_q;
    rows_d      = rows_q;
    sync1_d     = kbd.cols;
    sync2_d     = sync1_q;
    acc_valid_d = acc_valid_q;
    acc_code_d  = acc_code_q;

    if (w_sample) begin
      div_d  = 8'd0;
      row_d  = row_q + 2'd1;
      rows_d = ~(4'b0001 << row_d);
      if (row_q == 2'd0) begin
        // First row of a scan overwrites whatever the previous scan left
        acc_valid_d = w_hit;
        acc_code_d  = w_row_code;
      end else if (!acc_valid_q && w_hit) begin
        acc_valid_d = 1'b1;
        acc_code_d  = w_row_code;
      end
    end else begin
      div_d = div_q + 8'd1;
    end
  end

  // Debounce FSM: decisions only at scan end, except the one-cycle ACCEPT
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    rel_d    = rel_q;
    bus_d    = bus_q;
    strobe_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_scan_end && w_scan_valid) begin
          cand_d = w_scan_code;
          if (C_DEB == 4'd1) begin
            state_d = ST_ACCEPT;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_CAND;
            cnt_d   = 4'd1;
          end
        end
      end

      ST_CAND: begin
        if (w_scan_end) begin
          if (!w_scan_valid) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end else if (w_scan_code == cand_q) begin
            if (cnt_q + 4'd1 == C_DEB) begin
              state_d = ST_ACCEPT;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            // A different key restarts the count on the new candidate
            cand_d = w_scan_code;
            cnt_d  = 4'd1;
          end
        end
      end

      ST_ACCEPT: begin
        bus_d    = cand_q;
        strobe_d = 1'b1;
        rel_d    = 4'd0;
        state_d  = ST_HELD;
      end

      ST_HELD: begin
        if (w_scan_end) begin
          if (w_scan_valid) begin
            // Any key, including a different one, keeps the press held
            rel_d = 4'd0;
          end else if (rel_q + 4'd1 == C_DEB) begin
            state_d = ST_IDLE;
            rel_d   = 4'd0;
          end else begin
            rel_d = rel_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q       <= 8'd0;
      row_q       <= 2'd0;
      rows_q      <= 4'b1110;
      sync1_q     <= 4'b1111;
      sync2_q     <= 4'b1111;
      acc_valid_q <= 1'b0;
      acc_code_q  <= 4'h0;
      state_q     <= ST_IDLE;
      cand_q      <= 4'h0;
      cnt_q       <= 4'd0;
      rel_q       <= 4'd0;
      bus_q       <= 4'h0;
      strobe_q    <= 1'b0;
    end else begin
      div_q       <= div_d;
      row_q       <= row_d;
      rows_q      <= rows_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      acc_valid_q <= acc_valid_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      rel_q       <= rel_d;
      bus_q       <= bus_d;
      strobe_q    <= strobe_d;
    end
  end

  assign kbd.rows         = rows_q;
  assign kbd.keyboard_bus = bus_q;
  assign kbd.key_pressed  = strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Directed bench for keypad_scanner (SCAN_DIV=8,
//               DEBOUNCE_SCANS=3). A keypad matrix model pulls columns low
//               for pressed keys on the currently driven row.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_keypad_scanner;

  localparam int SD   = 8;
  localparam int DS   = 3;
  localparam int SCAN = 4 * SD;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] keys  = 16'h0000;
  logic [3:0]  cols_drv;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  keypad_scanner_if kif();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clock (clock),
    .reset (reset),
    .kbd   (kif)
  );

  always #5 clock = ~clock;

  // Keypad matrix: a pressed key shorts its column to the driven row
  always_comb begin
    cols_drv = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !kif.rows[r]) begin
          cols_drv[c] = 1'b0;
        end
      end
    end
  end
  assign kif.cols = cols_drv;

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Two reset edges; returns just after the last one with cyc = 0
  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic align_scan();
    while (cyc % SCAN != 0) tick();
  endtask

  // Advance n cycles, recording strobes: count, last code, first offset
  task automatic run_cycles(input int n, output int pulses,
                            output logic [3:0] code, output int first_at);
    pulses   = 0;
    code     = 4'h0;
    first_at = -1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (kif.key_pressed === 1'b1) begin
        pulses++;
        code = kif.keyboard_bus;
        if (first_at < 0) first_at = i + 1;
      end
    end
  endtask

  // Release everything long enough to return to IDLE, ending scan-aligned
  task automatic release_idle(output int pulses);
    logic [3:0] c;
    int f, p1, p2;
    keys = 16'h0000;
    p1 = 0;
    while (cyc % SCAN != 0) begin
      tick();
      if (kif.key_pressed === 1'b1) p1++;
    end
    run_cycles(DS * SCAN, p2, c, f);
    pulses = p1 + p2;
  endtask

  task automatic test_reset();
    logic [3:0] exp_rows;
    keys = 16'h0000;
    for (int i = 0; i < 13; i++) tick();
    do_reset();
    vectors++;
    if (kif.rows !== 4'b1110) begin
      errors++; $display("FAIL reset_rows: got %b expected %b", kif.rows, 4'b1110);
    end
    vectors++;
    if (kif.keyboard_bus !== 4'h0) begin
      errors++; $display("FAIL reset_bus: got %h expected 0", kif.keyboard_bus);
    end
    vectors++;
    if (kif.key_pressed !== 1'b0) begin
      errors++; $display("FAIL reset_strobe: got %b expected 0", kif.key_pressed);
    end
    for (int j = 0; j < SCAN; j++) begin
      exp_rows = ~(4'b0001 << (j / SD));
      vectors++;
      if (kif.rows !== exp_rows) begin
        errors++; $display("FAIL row_walk[%0d]: got %b expected %b", j, kif.rows, exp_rows);
      end
      tick();
    end
  endtask

  task automatic test_clean_press();
    int p, f;
    logic [3:0] c;
    keys = 16'h0040;  // row 1, col 2
    do_reset();
    run_cycles(100, p, c, f);
    vectors++;
    if (f !== 97) begin
      errors++; $display("FAIL clean_latency: got %0d expected 97", f);
    end
    vectors++;
    if (p !== 1) begin
      errors++; $display("FAIL clean_count: got %0d expected 1", p);
    end
    vectors++;
    if (c !== 4'h6) begin
      errors++; $display("FAIL clean_code: got %h expected 6", c);
    end
    run_cycles(20 * SCAN, p, c, f);
    vectors++;
    if (p !== 0) begin
      errors++; $display("FAIL clean_no_repeat: got %0d pulses expected 0", p);
    end
    vectors++;
    if (kif.keyboard_bus !== 4'h6) begin
      errors++; $display("FAIL clean_hold_bus: got %h expected 6", kif.keyboard_bus);
    end
  endtask

  task automatic test_bounce();
    int p, f, total;
    logic [3:0] c;
    release_idle(p);
    vectors++;
    if (p !== 0) begin
      errors++; $display("FAIL bounce_release: got %0d pulses expected 0", p);
    end
    total = 0;
    for (int k = 0; k < 5; k++) begin
      keys = 16'h0800;  // key B: row 2, col 3
      run_cycles(2 * SCAN, p, c, f);
      total += p;
      keys = 16'h0000;
      run_cycles(SCAN, p, c, f);
      total += p;
    end
    vectors++;
    if (total !== 0) begin
      errors++; $display("FAIL bounce_no_event: got %0d pulses expected 0", total);
    end
    vectors++;
    if (kif.keyboard_bus !== 4'h6) begin
      errors++; $display("FAIL bounce_bus_kept: got %h expected 6", kif.keyboard_bus);
    end
    keys = 16'h0800;
    run_cycles(100, p, c, f);
    vectors++;
    if (p !== 1 || c !== 4'hB || f !== 97) begin
      errors++; $display("FAIL bounce_accept: got %0d pulses code %h at %0d expected 1 pulse code b at 97", p, c, f);
    end
  endtask

  task automatic test_multi_key();
    int p, f;
    logic [3:0] c;
    release_idle(p);
    keys = 16'h0220;  // keys 5 and 9
    run_cycles(100, p, c, f);
    vectors++;
    if (p !== 1 || c !== 4'h5) begin
      errors++; $display("FAIL multi_lowest: got %0d pulses code %h expected 1 pulse code 5", p, c);
    end
    keys = 16'h0200;  // 5 released, 9 held
    run_cycles(5 * SCAN, p, c, f);
    vectors++;
    if (p !== 0) begin
      errors++; $display("FAIL multi_held: got %0d pulses expected 0", p);
    end
    vectors++;
    if (kif.keyboard_bus !== 4'h5) begin
      errors++; $display("FAIL multi_bus_kept: got %h expected 5", kif.keyboard_bus);
    end
    release_idle(p);
    keys = 16'h0200;
    run_cycles(100, p, c, f);
    vectors++;
    if (p !== 1 || c !== 4'h9) begin
      errors++; $display("FAIL multi_second: got %0d pulses code %h expected 1 pulse code 9", p, c);
    end
  endtask

  task automatic test_release_repress();
    int p, f;
    logic [3:0] c;
    release_idle(p);
    keys = 16'h0004;  // key 2
    run_cycles(4 * SCAN, p, c, f);
    vectors++;
    if (p !== 1 || c !== 4'h2) begin
      errors++; $display("FAIL repress_first: got %0d pulses code %h expected 1 pulse code 2", p, c);
    end
    keys = 16'h0000;
    run_cycles(2 * SCAN, p, c, f);
    keys = 16'h0004;
    run_cycles(4 * SCAN, p, c, f);
    vectors++;
    if (p !== 0) begin
      errors++; $display("FAIL repress_short_release: got %0d pulses expected 0", p);
    end
    keys = 16'h0000;
    run_cycles(DS * SCAN, p, c, f);
    keys = 16'h0004;
    run_cycles(100, p, c, f);
    vectors++;
    if (p !== 1 || c !== 4'h2 || f !== 97) begin
      errors++; $display("FAIL repress_second: got %0d pulses code %h at %0d expected 1 pulse code 2 at 97", p, c, f);
    end
  endtask

  task automatic test_reset_mid_debounce();
    int p, f;
    logic [3:0] c;
    release_idle(p);
    keys = 16'h4000;  // key E: row 3, col 2
    run_cycles(2 * SCAN, p, c, f);
    vectors++;
    if (p !== 0) begin
      errors++; $display("FAIL midrst_pre: got %0d pulses expected 0", p);
    end
    do_reset();
    vectors++;
    if (kif.keyboard_bus !== 4'h0 || kif.key_pressed !== 1'b0) begin
      errors++; $display("FAIL midrst_state: got bus %h strobe %b expected bus 0 strobe 0", kif.keyboard_bus, kif.key_pressed);
    end
    run_cycles(100, p, c, f);
    vectors++;
    if (p !== 1 || c !== 4'hE || f !== 97) begin
      errors++; $display("FAIL midrst_accept: got %0d pulses code %h at %0d expected 1 pulse code e at 97", p, c, f);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi_key();
    test_release_repress();
    test_reset_mid_debounce();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
